// File: rtl/gfx_pkg.sv
// gfx_pkg: shared constants and types for the pixel pipeline.
//   H_ACTIVE/V_ACTIVE : visible raster size
//   coord_t, bg_idx_t, spr_idx_t : pixel coordinate and palette index types
//   SPR_TRANSPARENT   : sprite texel value treated as see-through
//   sync_t / SYNC_RST : bundled {blank_n, hs_n, vs_n} and its idle value
//   frame_regs_t      : per-frame latched scroll/sprite placement
package gfx_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] bg_idx_t;
  typedef logic [2:0] spr_idx_t;

  localparam spr_idx_t SPR_TRANSPARENT = 3'd0;

  typedef struct packed {
    logic blank_n;
    logic hs_n;
    logic vs_n;
  } sync_t;

  localparam sync_t SYNC_RST = '{blank_n: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  typedef struct packed {
    logic [8:0]     scroll_x;
    coord_t         spr_x;
    coord_t         spr_y;
    logic [2:0]     spr_frame;
  } frame_regs_t;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register for {blank_n, hs_n, vs_n}.
//   Clk, Reset_n  : pixel clock, async active-low reset (stages reset to {0,1,1})
//   sync_i        : syncs entering the pipeline
//   sync_o        : syncs after DEPTH cycles
//   tap_blank_n_o : blank_n after DEPTH-1 cycles (for the stage before the output register)
module sync_delay_line
  import gfx_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic  Clk,
  input  logic  Reset_n,
  input  sync_t sync_i,
  output sync_t sync_o,
  output logic  tap_blank_n_o
);

  sync_t [DEPTH:1] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[1] = sync_i;
    for (int i = 2; i <= DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pipe_q <= {DEPTH{SYNC_RST}};
    else          pipe_q <= pipe_d;
  end

  assign sync_o        = pipe_q[DEPTH];
  assign tap_blank_n_o = pipe_q[DEPTH-1].blank_n;

endmodule

// File: rtl/pixel_index_fetch.sv
// pixel_index_fetch: per-pixel palette-index fetch for the background and
// one 2x-scaled sprite. Inputs at cycle t appear on the index outputs at t+3:
//   S1 registers ROM addresses, sprite box hit and syncs; S2 is the ROM read;
//   S3 registers indices, spr_hit and the delayed syncs.
// Ports:
//   Clk, Reset_n                 pixel clock, async active-low reset
//   DrawX, DrawY, blank_n, hs_n, vs_n   raster position and syncs from VGA ctrl
//   scroll_x, spr_x, spr_y, spr_frame, spr_flip   captured on vs_n falling edge
//   bg_rom_addr / bg_rom_data    background ROM (synchronous, 1-cycle read)
//   spr_rom_addr / spr_rom_data  sprite ROM (synchronous, 1-cycle read)
//   bg_index, spr_index, spr_hit indices for the palettes, sprite select
//   blank_n_o, hs_n_o, vs_n_o    syncs aligned with the index outputs
// Build option: define SPRITE_FLIP_EN to honour spr_flip (horizontal mirror);
// without it spr_flip is ignored.
module pixel_index_fetch
  import gfx_pkg::*;
#(
  parameter int BG_W       = 512,
  parameter int BG_H       = 240,
  parameter int SPR_W      = 16,
  parameter int SPR_FRAMES = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  coord_t      DrawX,
  input  coord_t      DrawY,
  input  logic        blank_n,
  input  logic        hs_n,
  input  logic        vs_n,
  input  logic [8:0]  scroll_x,
  input  coord_t      spr_x,
  input  coord_t      spr_y,
  input  logic [2:0]  spr_frame,
  input  logic        spr_flip,
  output logic [16:0] bg_rom_addr,
  input  logic [3:0]  bg_rom_data,
  output logic [10:0] spr_rom_addr,
  input  logic [2:0]  spr_rom_data,
  output bg_idx_t     bg_index,
  output spr_idx_t    spr_index,
  output logic        spr_hit,
  output logic        blank_n_o,
  output logic        hs_n_o,
  output logic        vs_n_o
);

  localparam int unsigned BG_WU       = BG_W;
  // Active rows are always < BG_H, so keep only the row bits a BG_H-tall ROM needs.
  localparam int unsigned BG_ROWS     = 1 << $clog2(BG_H);
  localparam int unsigned SPR_WU      = SPR_W;
  localparam int unsigned SPR_FRAMESU = SPR_FRAMES;
  localparam logic [9:0]  BOX         = 10'(2 * SPR_W);

  // ---------------- frame latch ----------------
  logic        vs_n_q, vs_n_d;
  frame_regs_t fr_q, fr_d;
  logic        vs_fall;
  logic        flip;

  assign vs_fall = vs_n_q & ~vs_n;
  assign vs_n_d  = vs_n;

  always_comb begin
    fr_d = fr_q;
    if (vs_fall) begin
      fr_d.scroll_x  = scroll_x;
      fr_d.spr_x     = spr_x;
      fr_d.spr_y     = spr_y;
      fr_d.spr_frame = spr_frame;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_n_q <= 1'b1;
      fr_q   <= '0;
    end else begin
      vs_n_q <= vs_n_d;
      fr_q   <= fr_d;
    end
  end

`ifdef SPRITE_FLIP_EN
  logic flip_q, flip_d;

  always_comb begin
    flip_d = flip_q;
    if (vs_fall) flip_d = spr_flip;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) flip_q <= 1'b0;
    else          flip_q <= flip_d;
  end

  assign flip = flip_q;
`else
  logic unused_flip;
  assign unused_flip = spr_flip;
  assign flip        = 1'b0;
`endif

  // ---------------- S1: address generation ----------------
  logic [10:0] dx_w, dy_w;
  int unsigned tx, ty, lx, ly, sx;
  logic [16:0] bg_addr_d, bg_rom_addr_q;
  logic [10:0] spr_addr_d, spr_rom_addr_q;
  logic        box_hit_d, box_hit_q, box_hit_d2_q;

  always_comb begin
    // 11-bit differences: bit 10 is the borrow, so a pixel left of / above
    // the sprite origin is a miss even where the 10-bit wrap would be small.
    dx_w      = {1'b0, DrawX} - {1'b0, fr_q.spr_x};
    dy_w      = {1'b0, DrawY} - {1'b0, fr_q.spr_y};
    box_hit_d = !dx_w[10] && (dx_w[9:0] < BOX) && !dy_w[10] && (dy_w[9:0] < BOX);

    tx = ((32'(DrawX) >> 1) + 32'(fr_q.scroll_x)) % BG_WU;
    ty = (32'(DrawY) >> 1) % BG_ROWS;
    lx = (32'(dx_w[9:0]) >> 1) % SPR_WU;
    ly = (32'(dy_w[9:0]) >> 1) % SPR_WU;
    sx = flip ? (SPR_WU - 1 - lx) : lx;

    bg_addr_d  = 17'(ty * BG_WU + tx);
    spr_addr_d = 11'((32'(fr_q.spr_frame) % SPR_FRAMESU) * SPR_WU * SPR_WU
                     + ly * SPR_WU + sx);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bg_rom_addr_q  <= '0;
      spr_rom_addr_q <= '0;
      box_hit_q      <= 1'b0;
      box_hit_d2_q   <= 1'b0;
    end else begin
      bg_rom_addr_q  <= bg_addr_d;
      spr_rom_addr_q <= spr_addr_d;
      box_hit_q      <= box_hit_d;
      box_hit_d2_q   <= box_hit_q;
    end
  end

  assign bg_rom_addr  = bg_rom_addr_q;
  assign spr_rom_addr = spr_rom_addr_q;

  // ---------------- sync alignment ----------------
  sync_t sync_in, sync_out;
  logic  blank_n_d2;

  assign sync_in = {blank_n, hs_n, vs_n};

  sync_delay_line #(.DEPTH(3)) u_sync_dly (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .sync_i        (sync_in),
    .sync_o        (sync_out),
    .tap_blank_n_o (blank_n_d2)
  );

  assign blank_n_o = sync_out.blank_n;
  assign hs_n_o    = sync_out.hs_n;
  assign vs_n_o    = sync_out.vs_n;

  // ---------------- S3: output register ----------------
  bg_idx_t  bg_index_d, bg_index_q;
  spr_idx_t spr_index_d, spr_index_q;
  logic     spr_hit_d, spr_hit_q;

  always_comb begin
    bg_index_d  = '0;
    spr_index_d = '0;
    spr_hit_d   = 1'b0;
    if (blank_n_d2) begin
      bg_index_d  = bg_rom_data;
      spr_index_d = spr_rom_data;
      spr_hit_d   = box_hit_d2_q && (spr_rom_data != SPR_TRANSPARENT);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bg_index_q  <= '0;
      spr_index_q <= '0;
      spr_hit_q   <= 1'b0;
    end else begin
      bg_index_q  <= bg_index_d;
      spr_index_q <= spr_index_d;
      spr_hit_q   <= spr_hit_d;
    end
  end

  assign bg_index  = bg_index_q;
  assign spr_index = spr_index_q;
  assign spr_hit   = spr_hit_q;

endmodule

// File: tb/tb_pixel_index_fetch.sv
// Bench for pixel_index_fetch: fixed vectors for the addressing corner cases,
// hand sequences for frame latching, reset and blanking, then randomized
// raster traffic checked cycle by cycle against a behavioural model.
module tb_pixel_index_fetch;
  import gfx_pkg::*;

`ifdef SPRITE_FLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  coord_t      DrawX, DrawY;
  logic        blank_n, hs_n, vs_n;
  logic [8:0]  scroll_x;
  coord_t      spr_x, spr_y;
  logic [2:0]  spr_frame;
  logic        spr_flip;
  logic [16:0] bg_rom_addr;
  logic [3:0]  bg_rom_data = '0;
  logic [10:0] spr_rom_addr;
  logic [2:0]  spr_rom_data = '0;
  bg_idx_t     bg_index;
  spr_idx_t    spr_index;
  logic        spr_hit, blank_n_o, hs_n_o, vs_n_o;

  always #5 Clk = ~Clk;

  pixel_index_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank_n(blank_n), .hs_n(hs_n), .vs_n(vs_n), .scroll_x(scroll_x),
    .spr_x(spr_x), .spr_y(spr_y), .spr_frame(spr_frame), .spr_flip(spr_flip),
    .bg_rom_addr(bg_rom_addr), .bg_rom_data(bg_rom_data),
    .spr_rom_addr(spr_rom_addr), .spr_rom_data(spr_rom_data),
    .bg_index(bg_index), .spr_index(spr_index), .spr_hit(spr_hit),
    .blank_n_o(blank_n_o), .hs_n_o(hs_n_o), .vs_n_o(vs_n_o)
  );

  // ---------------- ROM models ----------------
  logic [2:0] spr_mem [2048];

  function automatic logic [3:0] bgfn(input logic [16:0] a);
    return a[3:0] ^ a[7:4] ^ a[12:9] ^ {3'b000, a[16]};
  endfunction

  always @(posedge Clk) begin
    bg_rom_data  <= bgfn(bg_rom_addr);
    spr_rom_data <= spr_mem[spr_rom_addr];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int x, y;
    bit blank, hs, vs;
    int bg_addr, spr_addr;
    bit box;
  } hist_t;

  hist_t hist[$];
  int    nvalid;
  int    m_scroll, m_sx, m_sy, m_frame;
  bit    m_flip, m_prev_vs;

  task automatic model_reset();
    hist.delete();
    nvalid = 0;
    m_scroll = 0; m_sx = 0; m_sy = 0; m_frame = 0; m_flip = 0;
    m_prev_vs = 1;
  endtask

  function automatic hist_t predict();
    hist_t h;
    int dx, dy, lx, ly, sxx;
    h.x = int'(DrawX); h.y = int'(DrawY);
    h.blank = blank_n; h.hs = hs_n; h.vs = vs_n;
    h.bg_addr = ((h.y / 2) * 512 + ((h.x / 2 + m_scroll) % 512)) % 131072;
    dx = h.x - m_sx;
    dy = h.y - m_sy;
    h.box = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
    lx = dx / 2; ly = dy / 2;
    sxx = (FLIP_EN && m_flip) ? 15 - lx : lx;
    h.spr_addr = h.box ? (m_frame * 256 + ly * 16 + sxx) : 0;
    return h;
  endfunction

  task automatic check_reset();
    chk("rst_bg_rom_addr", int'(bg_rom_addr), 0);
    chk("rst_spr_rom_addr", int'(spr_rom_addr), 0);
    chk("rst_bg_index", int'(bg_index), 0);
    chk("rst_spr_index", int'(spr_index), 0);
    chk("rst_spr_hit", int'(spr_hit), 0);
    chk("rst_blank_n_o", int'(blank_n_o), 0);
    chk("rst_hs_n_o", int'(hs_n_o), 1);
    chk("rst_vs_n_o", int'(vs_n_o), 1);
  endtask

  task automatic check_pipe();
    hist_t hl, ho;
    int d;
    hl = hist[hist.size()-1];
    chk("bg_rom_addr", int'(bg_rom_addr), hl.bg_addr);
    if (hl.box) chk("spr_rom_addr", int'(spr_rom_addr), hl.spr_addr);
    if (nvalid >= 3) begin
      ho = hist[0];
      d = int'(spr_mem[ho.spr_addr]);
      chk("bg_index", int'(bg_index), ho.blank ? int'(bgfn(17'(ho.bg_addr))) : 0);
      chk("spr_hit", int'(spr_hit), (ho.box && d != 0 && ho.blank) ? 1 : 0);
      if (!ho.blank)   chk("spr_index_blank", int'(spr_index), 0);
      else if (ho.box) chk("spr_index", int'(spr_index), d);
      chk("blank_n_o", int'(blank_n_o), int'(ho.blank));
      chk("hs_n_o", int'(hs_n_o), int'(ho.hs));
      chk("vs_n_o", int'(vs_n_o), int'(ho.vs));
    end
  endtask

  // One pixel clock: record the model's view of the current inputs, advance,
  // then compare just after the edge.
  task automatic tick();
    hist_t h;
    if (Reset_n) begin
      h = predict();
      hist.push_back(h);
      if (hist.size() > 3) void'(hist.pop_front());
      if (m_prev_vs && !vs_n) begin
        m_scroll = int'(scroll_x); m_sx = int'(spr_x); m_sy = int'(spr_y);
        m_frame = int'(spr_frame); m_flip = spr_flip;
      end
      m_prev_vs = vs_n;
      nvalid++;
    end
    @(posedge Clk);
    #1;
    if (!Reset_n) check_reset();
    else          check_pipe();
  endtask

  task automatic idle_pixel();
    DrawX = 10'd700; DrawY = 10'd500; blank_n = 1'b0; hs_n = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string name;
    int    scroll, sx, sy, frame;
    bit    flip;
    int    x, y;
    int    exp_bg;
    bit    chk_spr;
    int    exp_spr;
    bit    exp_hit;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input int sc, input int sx, input int sy,
                     input int fr, input bit fl, input int x, input int y,
                     input int ebg, input bit cs, input int esp, input bit eh);
    vec_t v;
    v.name = nm; v.scroll = sc; v.sx = sx; v.sy = sy; v.frame = fr; v.flip = fl;
    v.x = x; v.y = y; v.exp_bg = ebg; v.chk_spr = cs; v.exp_spr = esp; v.exp_hit = eh;
    tbl.push_back(v);
  endtask

  // Latch the vector's frame values, then drive the pixel with different
  // (to-be-ignored) frame inputs and check address and hit.
  task automatic apply_vec(input vec_t v);
    scroll_x = 9'(v.scroll); spr_x = 10'(v.sx); spr_y = 10'(v.sy);
    spr_frame = 3'(v.frame); spr_flip = v.flip;
    idle_pixel(); vs_n = 1'b1; tick();
    vs_n = 1'b0; tick();
    vs_n = 1'b1;
    scroll_x = ~scroll_x; spr_x = ~spr_x; spr_y = ~spr_y;
    spr_frame = ~spr_frame; spr_flip = ~spr_flip;
    DrawX = 10'(v.x); DrawY = 10'(v.y); blank_n = 1'b1; hs_n = 1'b1;
    tick();
    chk({v.name, "_bg_addr"}, int'(bg_rom_addr), v.exp_bg);
    if (v.chk_spr) chk({v.name, "_spr_addr"}, int'(spr_rom_addr), v.exp_spr);
    idle_pixel(); tick(); tick();
    chk({v.name, "_hit"}, int'(spr_hit), int'(v.exp_hit));
  endtask

  int x, y;

  initial begin
    Reset_n = 1'b0;
    scroll_x = '0; spr_x = '0; spr_y = '0; spr_frame = '0; spr_flip = 1'b0;
    vs_n = 1'b1; idle_pixel();
    for (int i = 0; i < 2048; i++) spr_mem[i] = 3'($urandom_range(0, 7));
    spr_mem[512] = 3'd5; spr_mem[527] = 3'd6; spr_mem[752] = 3'd3;
    spr_mem[1808] = 3'd2; spr_mem[513] = 3'd0;
    model_reset();

    // reset state
    for (int i = 0; i < 3; i++) tick();
    Reset_n = 1'b1;
    model_reset();

    add("bg_basic",    0, 100, 50, 2, 0, 10, 20, 5125, 0, 0, 0);
    add("bg_wrap",   500, 100, 50, 2, 0, 30, 20, 5123, 0, 0, 0);
    add("spr_origin",  0, 100, 50, 2, 0, 100, 50, 12850, 1, 512, 1);
    add("spr_left",    0, 100, 50, 2, 0, 99, 50, 12849, 0, 0, 0);
    add("spr_redge",   0, 100, 50, 2, 0, 131, 50, 12865, 1, 527, 1);
    add("spr_rmiss",   0, 100, 50, 2, 0, 132, 50, 12866, 0, 0, 0);
    add("spr_bedge",   0, 100, 50, 2, 0, 100, 81, 20530, 1, 752, 1);
    add("spr_bmiss",   0, 100, 50, 2, 0, 100, 82, 21042, 0, 0, 0);
    add("spr_transp",  0, 100, 50, 2, 0, 102, 50, 12851, 1, 513, 0);
    add("spr_xwrap",   0, 1000, 50, 2, 0, 10, 50, 12805, 0, 0, 0);
    add("seam_511",  511, 1000, 1000, 0, 0, 0, 0, 511, 0, 0, 0);
    add("seam_0",    511, 1000, 1000, 0, 0, 2, 0, 0, 0, 0, 0);
    add("spr_frame7",  0, 0, 0, 7, 0, 1, 3, 512, 1, 1808, 1);
    add("spr_flip",    0, 100, 50, 2, 1, 100, 50, 12850, 1, FLIP_EN ? 527 : 512, 1);
    foreach (tbl[i]) apply_vec(tbl[i]);

    // mid-frame scroll change is held until after the next vs_n fall
    scroll_x = 9'd0; vs_n = 1'b0; idle_pixel(); tick();
    vs_n = 1'b1; tick();
    scroll_x = 9'd100; DrawX = 10'd10; DrawY = 10'd20; blank_n = 1'b1; tick();
    chk("midframe_hold", int'(bg_rom_addr), 5125);
    vs_n = 1'b0; tick();
    chk("edge_cycle", int'(bg_rom_addr), 5125);
    vs_n = 1'b1; tick();
    chk("after_fall", int'(bg_rom_addr), 5225);

    // blanking forces indices to zero even over an opaque sprite texel
    spr_x = 10'd100; spr_y = 10'd50; spr_frame = 3'd2; spr_flip = 1'b0;
    vs_n = 1'b0; idle_pixel(); tick();
    vs_n = 1'b1; DrawX = 10'd100; DrawY = 10'd50; blank_n = 1'b0; tick();
    idle_pixel(); tick(); tick();
    chk("blank_bg_index", int'(bg_index), 0);
    chk("blank_spr_index", int'(spr_index), 0);
    chk("blank_spr_hit", int'(spr_hit), 0);

    // randomized raster traffic
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        #3 Reset_n = 1'b0;
        #1 check_reset();
        tick(); tick();
        Reset_n = 1'b1;
        model_reset();
      end
      if ($urandom_range(0, 63) == 0) begin
        scroll_x  = 9'($urandom);
        spr_x     = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(640, 1023))
                                                : 10'($urandom_range(0, 639));
        spr_y     = 10'($urandom_range(0, 479));
        spr_frame = 3'($urandom);
        spr_flip  = 1'($urandom);
      end
      vs_n = ((i % 150) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        x = int'($urandom_range(0, 799));
        y = int'($urandom_range(0, 524));
      end else begin
        x = m_sx + int'($urandom_range(0, 40)) - 4;
        y = m_sy + int'($urandom_range(0, 40)) - 4;
        if (x < 0 || x > 799) x = int'($urandom_range(0, 799));
        if (y < 0 || y > 524) y = int'($urandom_range(0, 524));
      end
      DrawX   = 10'(x);
      DrawY   = 10'(y);
      blank_n = (x < 640) && (y < 480);
      hs_n    = !((x >= 656) && (x < 752));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
